// File: rtl/rect_raster_pkg.sv
// Shared draw package: default field widths, rectangle mode codes, raster FSM states.
// No logic; types and constants only.
// Imported by rect_raster and rect_raster_ctrl.
package rect_raster_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int DIM_W_DEF   = 6;
  localparam int COLOR_W_DEF = 3;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rect_raster_ctrl.sv
// Raster sequencing FSM: IDLE accepts a request, RUN streams pixels, DONE pulses completion.
// Latency: pixel valid the cycle after start is sampled; done one cycle after the last transfer.
// Backpressure: advances only on pix_ready; valid is masked while reset is asserted.
module rect_raster_ctrl
  import rect_raster_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic start_i,
  input  logic dim_zero_i,
  input  logic last_i,
  input  logic pix_ready_i,
  output logic load_o,
  output logic step_o,
  output logic pix_valid_o,
  output logic busy_o,
  output logic done_o
);

  state_t state_q, state_d;

  // State register, synchronous active-low reset back to IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and per-state outputs; a reset cycle never presents a pixel.
  always_comb begin
    state_d     = state_q;
    load_o      = 1'b0;
    step_o      = 1'b0;
    pix_valid_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          state_d = dim_zero_i ? DONE : RUN;
        end
      end
      RUN: begin
        busy_o      = 1'b1;
        pix_valid_o = resetn;
        if (pix_ready_i && resetn) begin
          step_o = 1'b1;
          if (last_i) state_d = DONE;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/rect_raster.sv
// Rectangle rasteriser: emits (x+c, y+r) row-major, solid fill or outline only.
// Latency: first pixel one cycle after start; one pixel per cycle when downstream is ready.
// Backpressure: pix_ready low holds the presented pixel stable; counters advance only on transfer.
module rect_raster
  import rect_raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int DIM_W   = DIM_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [DIM_W-1:0]   w_in,
  input  logic [DIM_W-1:0]   h_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               mode,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               done
);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [DIM_W-1:0]   w_q, w_d, h_q, h_d, c_q, c_d, r_q, r_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               mode_q, mode_d;

  logic load, step, dim_zero;
  logic last_col, last_row, outline_mid;

  assign dim_zero    = (w_in == '0) || (h_in == '0);
  assign last_col    = (c_q == w_q - DIM_W'(1));
  assign last_row    = (r_q == h_q - DIM_W'(1));
  // Interior rows of an outline only carry the two edge pixels.
  assign outline_mid = (mode_q == MODE_OUTLINE) && (r_q != '0) && !last_row;

  rect_raster_ctrl u_ctrl (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (start),
    .dim_zero_i  (dim_zero),
    .last_i      (last_col && last_row),
    .pix_ready_i (pix_ready),
    .load_o      (load),
    .step_o      (step),
    .pix_valid_o (pix_valid),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Latch the request on acceptance, then walk columns inside rows on each transfer.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    mode_d  = mode_q;
    c_d     = c_q;
    r_d     = r_q;
    if (load) begin
      x_d     = x_in;
      y_d     = y_in;
      w_d     = w_in;
      h_d     = h_in;
      color_d = color_in;
      mode_d  = mode;
      c_d     = '0;
      r_d     = '0;
    end else if (step) begin
      if (last_col) begin
        c_d = '0;
        r_d = r_q + DIM_W'(1);
      end else if (outline_mid) begin
        c_d = w_q - DIM_W'(1);
      end else begin
        c_d = c_q + DIM_W'(1);
      end
    end
  end

  // Datapath registers; reset clears them so the pixel outputs read zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      mode_q  <= MODE_FILL;
      c_q     <= '0;
      r_q     <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      r_q     <= r_d;
    end
  end

  // Coordinates wrap modulo 2^COORD_W; the carry out is dropped.
  assign pix_x     = x_q + COORD_W'(c_q);
  assign pix_y     = y_q + COORD_W'(r_q);
  assign pix_color = color_q;

endmodule
